shift_sequencer: RTL and testbench

Command-driven controller that sequences an external logical shift register (clear/load/shift-left/shift-right control interface, WIDTH-bit data). It accepts one command over a ready/start handshake, loads the word, and issues a programmable number of shift pulses spaced by a programmable divider. Each shifted-out bit is presented as a serial stream, and the final register contents are captured as a result. It sits between a host/CPU-side command source and the shift register datapath.

---
 rtl/shift_sequencer_if.sv | 47 ++++
 rtl/shift_sequencer.sv | 152 +++++++++++++++
 tb/tb_shift_sequencer.sv | 336 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/shift_sequencer_if.sv
// Signal bundle between a host command source, shift_sequencer and the external
// shift register it controls. The sequencer uses the slave view.
interface shift_sequencer_if #(
    parameter int WIDTH       = 4,
    parameter int COUNT_WIDTH = 3,
    parameter int DIV_WIDTH   = 8
);
    logic                   start;
    logic                   ready;
    logic                   abort;
    logic                   cmd_dir;
    logic [COUNT_WIDTH-1:0] cmd_count;
    logic                   cmd_fill;
    logic [DIV_WIDTH-1:0]   cmd_div;
    logic [WIDTH-1:0]       cmd_data;

    logic                   sr_clear;
    logic                   sr_load;
    logic                   sr_shift_left;
    logic                   sr_shift_right;
    logic                   sr_shift_in;
    logic [WIDTH-1:0]       sr_d;
    logic [WIDTH-1:0]       sr_q;
    logic                   sr_shift_out;

    logic                   serial_bit;
    logic                   serial_valid;
    logic                   done;
    logic                   aborted;
    logic [WIDTH-1:0]       result;
    logic                   busy;

    // Environment side: issues commands and plays the shift register.
    modport master (
        output start, abort, cmd_dir, cmd_count, cmd_fill, cmd_div, cmd_data,
        output sr_q, sr_shift_out,
        input  ready, busy, done, aborted, result, serial_bit, serial_valid,
        input  sr_clear, sr_load, sr_shift_left, sr_shift_right, sr_shift_in, sr_d
    );

    modport slave (
        input  start, abort, cmd_dir, cmd_count, cmd_fill, cmd_div, cmd_data,
        input  sr_q, sr_shift_out,
        output ready, busy, done, aborted, result, serial_bit, serial_valid,
        output sr_clear, sr_load, sr_shift_left, sr_shift_right, sr_shift_in, sr_d
    );
endinterface

// File: rtl/shift_sequencer.sv
// Command-driven sequencer for an external shift register: load a word, issue a
// programmable number of divider-spaced shifts, stream shifted-out bits, capture result.
module shift_sequencer #(
    parameter int WIDTH       = 4,
    parameter int COUNT_WIDTH = 3,
    parameter int DIV_WIDTH   = 8
) (
    input  logic              clock,
    input  logic              reset,
    shift_sequencer_if.slave  bus
);
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_SHIFT = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = COUNT_WIDTH'(WIDTH);
    localparam logic [COUNT_WIDTH-1:0] COUNT_ONE = COUNT_WIDTH'(1);
    localparam logic [DIV_WIDTH-1:0]   DIV_ONE   = DIV_WIDTH'(1);

    logic [2:0]             state;
    logic                   dir_r;
    logic                   fill_r;
    logic [DIV_WIDTH-1:0]   div_r;
    logic [WIDTH-1:0]       data_r;
    logic [COUNT_WIDTH-1:0] rem_cnt;
    logic [DIV_WIDTH-1:0]   wait_cnt;
    logic [WIDTH-1:0]       result_r;
    logic                   abort_ack;

    // Abort only counts while a command is in flight; it then silences every
    // state action this cycle, as does a synchronous reset.
    logic cancel;
    logic quiet;
    assign cancel = bus.abort && (state != ST_IDLE);
    assign quiet  = cancel || reset;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ST_IDLE;
            dir_r     <= 1'b0;
            fill_r    <= 1'b0;
            div_r     <= '0;
            data_r    <= '0;
            rem_cnt   <= '0;
            wait_cnt  <= '0;
            result_r  <= '0;
            abort_ack <= 1'b0;
        end else begin
            abort_ack <= 1'b0;
            if (cancel) begin
                state     <= ST_IDLE;
                abort_ack <= 1'b1;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (bus.start) begin
                            dir_r   <= bus.cmd_dir;
                            fill_r  <= bus.cmd_fill;
                            div_r   <= bus.cmd_div;
                            data_r  <= bus.cmd_data;
                            rem_cnt <= (bus.cmd_count > COUNT_MAX) ? COUNT_MAX : bus.cmd_count;
                            state   <= ST_LOAD;
                        end
                    end
                    ST_LOAD: begin
                        if (rem_cnt == '0) begin
                            state <= ST_DONE;
                        end else if (div_r == '0) begin
                            state <= ST_SHIFT;
                        end else begin
                            wait_cnt <= div_r;
                            state    <= ST_WAIT;
                        end
                    end
                    ST_WAIT: begin
                        if (wait_cnt == DIV_ONE) begin
                            state <= ST_SHIFT;
                        end else begin
                            wait_cnt <= wait_cnt - DIV_ONE;
                        end
                    end
                    ST_SHIFT: begin
                        rem_cnt <= rem_cnt - COUNT_ONE;
                        if (rem_cnt == COUNT_ONE) begin
                            state <= ST_DONE;
                        end else if (div_r == '0) begin
                            state <= ST_SHIFT;
                        end else begin
                            wait_cnt <= div_r;
                            state    <= ST_WAIT;
                        end
                    end
                    ST_DONE: begin
                        result_r <= bus.sr_q;
                        state    <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    // NOTE: every output gets a default before the case so no path leaves a
    // variable unassigned, which would otherwise infer a latch.
    always_comb begin
        bus.ready          = (state == ST_IDLE);
        bus.busy           = (state != ST_IDLE);
        bus.result         = result_r;
        bus.sr_clear       = abort_ack;
        bus.aborted        = abort_ack;
        bus.sr_load        = 1'b0;
        bus.sr_d           = '0;
        bus.sr_shift_left  = 1'b0;
        bus.sr_shift_right = 1'b0;
        bus.sr_shift_in    = 1'b0;
        bus.serial_valid   = 1'b0;
        bus.serial_bit     = 1'b0;
        bus.done           = 1'b0;
        if (!quiet) begin
            case (state)
                ST_LOAD: begin
                    bus.sr_load = 1'b1;
                    bus.sr_d    = data_r;
                end
                ST_SHIFT: begin
                    bus.sr_shift_left  = dir_r;
                    bus.sr_shift_right = !dir_r;
                    bus.sr_shift_in    = fill_r;
                    bus.serial_valid   = 1'b1;
                    bus.serial_bit     = bus.sr_shift_out;
                end
                ST_DONE: bus.done = 1'b1;
                default: ;
            endcase
        end
    end

    // The register must never see two control pulses in one cycle.
    a_one_pulse: assert property (@(posedge clock) disable iff (reset)
        $onehot0({bus.sr_clear, bus.sr_load, bus.sr_shift_left, bus.sr_shift_right}));

    a_done_xor_abort: assert property (@(posedge clock) disable iff (reset)
        !(bus.done && bus.aborted));

    a_data_quiet: assert property (@(posedge clock) disable iff (reset)
        !bus.sr_load |-> (bus.sr_d == '0));

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer with a behavioural shift register attached.
module tb_shift_sequencer;
    localparam int WIDTH       = 4;
    localparam int COUNT_WIDTH = 3;
    localparam int DIV_WIDTH   = 8;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [WIDTH-1:0] sr_model = '0;

    shift_sequencer_if #(.WIDTH(WIDTH), .COUNT_WIDTH(COUNT_WIDTH), .DIV_WIDTH(DIV_WIDTH)) bus ();

    shift_sequencer #(.WIDTH(WIDTH), .COUNT_WIDTH(COUNT_WIDTH), .DIV_WIDTH(DIV_WIDTH)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // External shift register driven by the sequencer's pulses.
    always @(posedge clock) begin
        if (bus.sr_clear)            sr_model <= '0;
        else if (bus.sr_load)        sr_model <= bus.sr_d;
        else if (bus.sr_shift_left)  sr_model <= {sr_model[WIDTH-2:0], bus.sr_shift_in};
        else if (bus.sr_shift_right) sr_model <= {bus.sr_shift_in, sr_model[WIDTH-1:1]};
    end
    assign bus.sr_q         = sr_model;
    assign bus.sr_shift_out = bus.sr_shift_left ? sr_model[WIDTH-1] : sr_model[0];

    // Flags: ready busy clear load left right serial_valid done aborted
    function automatic logic [8:0] obs_vec();
        return {bus.ready, bus.busy, bus.sr_clear, bus.sr_load, bus.sr_shift_left,
                bus.sr_shift_right, bus.serial_valid, bus.done, bus.aborted};
    endfunction

    // I idle, A idle after abort, L load, W wait/silenced, l/r shift, D done
    function automatic logic [8:0] exp_vec(input byte code);
        case (code)
            "I":     return 9'b100000000;
            "A":     return 9'b101000001;
            "L":     return 9'b010100000;
            "W":     return 9'b010000000;
            "l":     return 9'b010010100;
            "r":     return 9'b010001100;
            "D":     return 9'b010000010;
            default: return 9'bxxxxxxxxx;
        endcase
    endfunction

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic issue(input logic dir, input logic [COUNT_WIDTH-1:0] count, input logic fill,
                         input logic [DIV_WIDTH-1:0] div, input logic [WIDTH-1:0] data);
        bus.start     = 1'b1;
        bus.cmd_dir   = dir;
        bus.cmd_count = count;
        bus.cmd_fill  = fill;
        bus.cmd_div   = div;
        bus.cmd_data  = data;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        issue(1'b1, 3'd4, 1'b1, 8'd0, 4'b1111);
        bus.abort = 1'b1;
        repeat (3) next_cycle();
        reset = 1'b0;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        @(negedge clock);
        n_checks++;
        if (obs_vec() !== exp_vec("I")) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected %b", obs_vec(), exp_vec("I"));
        end
        n_checks++;
        if ({bus.result, bus.sr_d, bus.sr_shift_in, bus.serial_bit} !== 10'd0) begin
            n_fail++;
            $display("FAIL reset_data: result=%b sr_d=%b shift_in=%b serial_bit=%b expected all 0",
                     bus.result, bus.sr_d, bus.sr_shift_in, bus.serial_bit);
        end
    endtask

    task automatic test_shift_right();
        string pat = "LrrrrDI";
        logic [3:0] bits = 4'b1011;
        int si = 0;
        next_cycle();
        issue(1'b0, 3'd4, 1'b0, 8'd0, 4'b1011);
        for (int i = 0; i < pat.len(); i++) begin
            next_cycle();
            bus.start = 1'b0;
            @(negedge clock);
            n_checks++;
            if (obs_vec() !== exp_vec(pat[i])) begin
                n_fail++;
                $display("FAIL shift_right T+%0d flags: got %b expected %b", i + 1, obs_vec(), exp_vec(pat[i]));
            end
            if (pat[i] == "L") begin
                n_checks++;
                if (bus.sr_d !== 4'b1011) begin
                    n_fail++;
                    $display("FAIL shift_right sr_d: got %b expected 1011", bus.sr_d);
                end
            end
            if (pat[i] == "r") begin
                n_checks++;
                if (bus.serial_bit !== bits[si]) begin
                    n_fail++;
                    $display("FAIL shift_right serial %0d: got %b expected %b", si, bus.serial_bit, bits[si]);
                end
                si++;
            end
        end
        n_checks++;
        if (bus.result !== 4'b0000) begin
            n_fail++;
            $display("FAIL shift_right result: got %b expected 0000", bus.result);
        end
    endtask

    task automatic test_shift_left_div();
        string pat = "LWWlWWlDI";
        logic [1:0] bits = 2'b01;
        int si = 0;
        next_cycle();
        issue(1'b1, 3'd2, 1'b1, 8'd2, 4'b1001);
        for (int i = 0; i < pat.len(); i++) begin
            next_cycle();
            bus.start = 1'b0;
            @(negedge clock);
            n_checks++;
            if (obs_vec() !== exp_vec(pat[i])) begin
                n_fail++;
                $display("FAIL shift_left T+%0d flags: got %b expected %b", i + 1, obs_vec(), exp_vec(pat[i]));
            end
            if (pat[i] == "l") begin
                n_checks++;
                if ({bus.serial_bit, bus.sr_shift_in} !== {bits[si], 1'b1}) begin
                    n_fail++;
                    $display("FAIL shift_left serial/fill %0d: got %b%b expected %b1",
                             si, bus.serial_bit, bus.sr_shift_in, bits[si]);
                end
                si++;
            end
        end
        n_checks++;
        if (bus.result !== 4'b0111) begin
            n_fail++;
            $display("FAIL shift_left result: got %b expected 0111", bus.result);
        end
    endtask

    task automatic test_count_bounds();
        string pat0 = "LDI";
        string pat7 = "LrrrrDI";
        logic [3:0] bits = 4'b0110;
        int si = 0;
        next_cycle();
        issue(1'b0, 3'd0, 1'b0, 8'd0, 4'b0110);
        for (int i = 0; i < pat0.len(); i++) begin
            next_cycle();
            bus.start = 1'b0;
            @(negedge clock);
            n_checks++;
            if (obs_vec() !== exp_vec(pat0[i])) begin
                n_fail++;
                $display("FAIL count_zero T+%0d flags: got %b expected %b", i + 1, obs_vec(), exp_vec(pat0[i]));
            end
        end
        n_checks++;
        if (bus.result !== 4'b0110) begin
            n_fail++;
            $display("FAIL count_zero result: got %b expected 0110", bus.result);
        end
        next_cycle();
        issue(1'b0, 3'd7, 1'b1, 8'd0, 4'b0110);
        for (int i = 0; i < pat7.len(); i++) begin
            next_cycle();
            bus.start = 1'b0;
            @(negedge clock);
            n_checks++;
            if (obs_vec() !== exp_vec(pat7[i])) begin
                n_fail++;
                $display("FAIL count_sat T+%0d flags: got %b expected %b", i + 1, obs_vec(), exp_vec(pat7[i]));
            end
            if (pat7[i] == "r") begin
                n_checks++;
                if (bus.serial_bit !== bits[si]) begin
                    n_fail++;
                    $display("FAIL count_sat serial %0d: got %b expected %b", si, bus.serial_bit, bits[si]);
                end
                si++;
            end
        end
        n_checks++;
        if (bus.result !== 4'b1111) begin
            n_fail++;
            $display("FAIL count_sat result: got %b expected 1111", bus.result);
        end
    endtask

    task automatic test_abort();
        string pat_w = "LWWAII";
        string pat_s = "LWAI";
        next_cycle();
        issue(1'b0, 3'd2, 1'b0, 8'd3, 4'b1100);
        for (int i = 0; i < pat_w.len(); i++) begin
            next_cycle();
            if (i == 1) issue(1'b1, 3'd1, 1'b0, 8'd0, 4'b0001);
            else bus.start = 1'b0;
            bus.abort = (i == 2);
            @(negedge clock);
            n_checks++;
            if (obs_vec() !== exp_vec(pat_w[i])) begin
                n_fail++;
                $display("FAIL abort_wait T+%0d flags: got %b expected %b", i + 1, obs_vec(), exp_vec(pat_w[i]));
            end
        end
        next_cycle();
        issue(1'b1, 3'd3, 1'b0, 8'd0, 4'b1010);
        for (int i = 0; i < pat_s.len(); i++) begin
            next_cycle();
            bus.start = 1'b0;
            bus.abort = (i == 1);
            @(negedge clock);
            n_checks++;
            if (obs_vec() !== exp_vec(pat_s[i])) begin
                n_fail++;
                $display("FAIL abort_shift T+%0d flags: got %b expected %b", i + 1, obs_vec(), exp_vec(pat_s[i]));
            end
        end
        n_checks++;
        if (bus.result !== 4'b1111) begin
            n_fail++;
            $display("FAIL abort_result: got %b expected 1111", bus.result);
        end
    endtask

    task automatic test_abort_idle();
        string pat = "LDI";
        next_cycle();
        issue(1'b0, 3'd0, 1'b0, 8'd0, 4'b0101);
        bus.abort = 1'b1;
        for (int i = 0; i < pat.len(); i++) begin
            next_cycle();
            bus.start = 1'b0;
            bus.abort = 1'b0;
            @(negedge clock);
            n_checks++;
            if (obs_vec() !== exp_vec(pat[i])) begin
                n_fail++;
                $display("FAIL abort_idle T+%0d flags: got %b expected %b", i + 1, obs_vec(), exp_vec(pat[i]));
            end
        end
        n_checks++;
        if (bus.result !== 4'b0101) begin
            n_fail++;
            $display("FAIL abort_idle result: got %b expected 0101", bus.result);
        end
    endtask

    task automatic test_reset_mid();
        string pat = "LWrW?I";
        string pat2 = "LlDI";
        next_cycle();
        issue(1'b0, 3'd4, 1'b0, 8'd1, 4'b1011);
        for (int i = 0; i < pat.len(); i++) begin
            next_cycle();
            bus.start = 1'b0;
            reset = (i == 4);
            @(negedge clock);
            if (pat[i] != "?") begin
                n_checks++;
                if (obs_vec() !== exp_vec(pat[i])) begin
                    n_fail++;
                    $display("FAIL reset_mid T+%0d flags: got %b expected %b", i + 1, obs_vec(), exp_vec(pat[i]));
                end
            end
        end
        n_checks++;
        if (bus.result !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_mid result: got %b expected 0000", bus.result);
        end
        next_cycle();
        issue(1'b1, 3'd1, 1'b0, 8'd0, 4'b0011);
        for (int i = 0; i < pat2.len(); i++) begin
            next_cycle();
            bus.start = 1'b0;
            @(negedge clock);
            n_checks++;
            if (obs_vec() !== exp_vec(pat2[i])) begin
                n_fail++;
                $display("FAIL after_reset T+%0d flags: got %b expected %b", i + 1, obs_vec(), exp_vec(pat2[i]));
            end
            if (pat2[i] == "l") begin
                n_checks++;
                if (bus.serial_bit !== 1'b0) begin
                    n_fail++;
                    $display("FAIL after_reset serial: got %b expected 0", bus.serial_bit);
                end
            end
        end
        n_checks++;
        if (bus.result !== 4'b0110) begin
            n_fail++;
            $display("FAIL after_reset result: got %b expected 0110", bus.result);
        end
    endtask

    initial begin
        bus.start     = 1'b0;
        bus.abort     = 1'b0;
        bus.cmd_dir   = 1'b0;
        bus.cmd_count = '0;
        bus.cmd_fill  = 1'b0;
        bus.cmd_div   = '0;
        bus.cmd_data  = '0;
        test_reset();
        test_shift_right();
        test_shift_left_div();
        test_count_bounds();
        test_abort();
        test_abort_idle();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
